// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host deframer feeding a scan-code FIFO with level ready and strobe pop.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       kbdi_clk,
    input  logic       kbdi_rst,
    input  logic       kbdi_ps2_clk,
    input  logic       kbdi_ps2_data,
    input  logic       kbdi_rdn,
    output logic       kbdo_data_ready,
    output logic [7:0] kbdo_scan_code,
    output logic       kbdo_frame_err,
    output logic       kbdo_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, parity;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [TW-1:0] timeout;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]   count;
    logic          fall, ps2_bit, frame_ok, push, pop, full, wr_en;
    logic [7:0]    head_nxt;

    assign fall     = clk_prev & ~clk_sync[1];
    assign ps2_bit  = data_sync[1];
    assign frame_ok = ps2_bit & ^{shift_reg, parity};
    assign push     = state == RECV && fall && bit_cnt == 4'd10 && frame_ok;
    assign full     = count == FULL_CNT;
    assign pop      = ~kbdi_rdn && |count;
    assign wr_en    = push && (!full || pop);
    assign rd_nxt   = rd_ptr + 1'b1;
    assign kbdo_data_ready = |count;
    // The head register keeps the last popped code once the FIFO drains.
    assign head_nxt = pop ? (|count[AW:1] ? mem[rd_nxt] : (push ? shift_reg : kbdo_scan_code))
                          : ((push && ~|count) ? shift_reg : kbdo_scan_code);

    always_ff @(posedge kbdi_clk or negedge kbdi_rst) begin
        if (!kbdi_rst) begin
            state          <= IDLE;
            clk_sync       <= 2'b11;
            data_sync      <= 2'b11;
            clk_prev       <= 1'b1;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            parity         <= 1'b0;
            timeout        <= '0;
            kbdo_frame_err <= 1'b0;
        end else begin
            clk_sync       <= {clk_sync[0], kbdi_ps2_clk};
            data_sync      <= {data_sync[0], kbdi_ps2_data};
            clk_prev       <= clk_sync[1];
            kbdo_frame_err <= 1'b0;
            if (state == IDLE) begin
                timeout <= '0;
                if (fall && !ps2_bit) begin
                    state   <= RECV;
                    bit_cnt <= 4'd1;
                end
            end else if (fall) begin
                timeout <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt <= 4'd8) shift_reg <= {ps2_bit, shift_reg[7:1]};
                if (bit_cnt == 4'd9) parity <= ps2_bit;
                if (bit_cnt == 4'd10) begin
                    state          <= IDLE;
                    bit_cnt        <= '0;
                    kbdo_frame_err <= !frame_ok;
                end
            end else if (timeout == TO_LAST) begin
                state          <= IDLE;
                bit_cnt        <= '0;
                timeout        <= '0;
                kbdo_frame_err <= 1'b1;
            end else begin
                timeout <= timeout + 1'b1;
            end
        end
    end

    always_ff @(posedge kbdi_clk) begin
        if (wr_en) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge kbdi_clk or negedge kbdi_rst) begin
        if (!kbdi_rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            kbdo_scan_code <= '0;
            kbdo_overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_nxt;
            count          <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            kbdo_scan_code <= head_nxt;
            if (push && full && !pop) kbdo_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: randomized PS/2 frames checked against a queue-based model of the receiver.
module tb_ps2_keyboard_rx;
    localparam int DEPTH = 4;
    localparam int TO    = 200;

    logic       clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, rdn = 1;
    logic       data_ready, frame_err, overflow;
    logic [7:0] scan_code;

    int         n_checks = 0, n_errors = 0, err_seen = 0, exp_err = 0, h = 12;
    bit         ov = 0;
    logic [7:0] q[$];
    logic [7:0] last = 0;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .kbdi_clk(clk), .kbdi_rst(rst_n), .kbdi_ps2_clk(ps2_clk), .kbdi_ps2_data(ps2_data),
        .kbdi_rdn(rdn), .kbdo_data_ready(data_ready), .kbdo_scan_code(scan_code),
        .kbdo_frame_err(frame_err), .kbdo_overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, input bit pop_now);
        logic [10:0] f;
        bit p;
        p = ($countones(code) % 2 == 0) ^ bad_par;
        f = {~bad_stop, p, code, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ps2_data = f[i];
            tick(h);
            ps2_clk = 0;
            tick(h);
            ps2_clk = 1;
        end
        ps2_data = f[10];
        tick(h);
        ps2_clk = 0;
        tick(2);
        if (pop_now) begin
            if (q.size() != 0) chk("head_before_pop", scan_code, q[0]);
            rdn = 0;
        end
        tick(1);
        rdn = 1;
        if (pop_now && q.size() != 0) last = q.pop_front();
        if (!bad_par && !bad_stop) begin
            if (q.size() < DEPTH) q.push_back(code);
            else ov = 1;
        end else exp_err++;
        chk("ready_after_stop", data_ready, q.size() != 0);
        chk("head_after_stop", scan_code, q.size() != 0 ? q[0] : last);
        tick(h - 3);
        ps2_clk  = 1;
        ps2_data = 1;
        tick(h);
        chk("frame_err_count", err_seen, exp_err);
        chk("overflow", overflow, ov);
    endtask

    task automatic partial(input logic [7:0] code, input int n);
        logic [10:0] f;
        f = {2'b11, code, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(h);
            ps2_clk = 0;
            if (i < n - 1) begin
                tick(h);
                ps2_clk = 1;
            end
        end
    endtask

    task automatic rd();
        chk("ready_before_read", data_ready, q.size() != 0);
        chk("head_before_read", scan_code, q.size() != 0 ? q[0] : last);
        rdn = 0;
        tick(1);
        rdn = 1;
        if (q.size() != 0) last = q.pop_front();
        tick(1);
        chk("ready_after_read", data_ready, q.size() != 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick(3);
        ps2_clk  = 1;
        ps2_data = 1;
        tick(1);
        chk("rst_ready", data_ready, 0);
        chk("rst_code", scan_code, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1;
        tick(5);
        q.delete();
        ov   = 0;
        last = 0;
    endtask

    initial begin
        int cnt;
        int e;
        tick(3);
        chk("init_ready", data_ready, 0);
        chk("init_code", scan_code, 0);
        chk("init_err", frame_err, 0);
        chk("init_ovf", overflow, 0);
        rst_n = 1;
        tick(5);

        send_frame(8'h1C, 0, 0, 0);
        rd();
        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'h1C, 0, 1, 0);

        partial(8'hA5, 5);
        cnt = 0;
        while (!frame_err && cnt < 1000) begin
            tick(1);
            cnt++;
            if (cnt == 10) ps2_clk = 1;
        end
        exp_err++;
        chk("timeout_latency", cnt, TO + 3);
        tick(h);
        chk("timeout_err_count", err_seen, exp_err);
        send_frame(8'hF0, 0, 0, 0);
        rd();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
        chk("ovf_after_five", overflow, 1);
        for (int i = 0; i < 5; i++) rd();
        chk("ovf_sticky", overflow, 1);

        do_reset();
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 0, 1);
        chk("simul_head", scan_code, 8'h22);
        rd();

        partial(8'h3C, 5);
        do_reset();
        send_frame(8'h5A, 0, 0, 0);
        rd();
        chk("post_reset_ovf", overflow, 0);

        for (int i = 0; i < 30; i++) begin
            h = $urandom_range(8, 20);
            e = $urandom_range(0, 7);
            send_frame(8'($urandom), e == 0, e == 1, e == 2);
            if ($urandom_range(0, 2) == 0) rd();
        end
        while (q.size() != 0) rd();
        rd();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
